// File: rtl/gpio_seq.sv
// gpio_seq: timed bit-bang sequencer that plays buffered {value, be, delay} entries onto the GPIO data register write port.
// Looping playback (extra i_loop port) is compiled in when GPIO_SEQ_LOOP_EN is defined.
module gpio_seq #(
   parameter int AW    = 4,
   parameter int DLY_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [31:0]      i_value,
   input  logic [3:0]       i_be,
   input  logic [DLY_W-1:0] i_delay,
   output logic             o_full,
   output logic [AW:0]      o_level,
   input  logic             i_start,
   input  logic             i_stop,
`ifdef GPIO_SEQ_LOOP_EN
   input  logic             i_loop,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [2:0]       o_gpio_addr,
   output logic [31:0]      o_gpio_din,
   output logic [3:0]       o_gpio_wr_en
);

   localparam int DEPTH = 1 << AW;
   localparam int EW    = 36 + DLY_W;
   localparam logic [AW:0]      LVL_ZERO = '0;
   localparam logic [AW:0]      LVL_ONE  = 1;
   localparam logic [AW:0]      LVL_FULL = DEPTH;
   localparam logic [DLY_W-1:0] DLY_ZERO = '0;
   localparam logic [DLY_W-1:0] DLY_ONE  = 1;

   typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

   state_t            state_reg, state_next;
   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, idx_reg, pos_reg;
   logic [AW-1:0]     head_addr, pos_next;
   logic [AW:0]       level_reg, level_next;
   logic [DLY_W-1:0]  cnt_reg, dly_reg;
   logic [31:0]       din_reg;
   logic [3:0]        be_reg;
   logic              done_reg, done_next;
   logic              load_head, last_entry, push_ok, pop, loop_run;

`ifdef GPIO_SEQ_LOOP_EN
   logic loop_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         loop_reg <= 1'b0;
      else if (state_reg == IDLE && i_start)
         loop_reg <= i_loop;
   end

   assign loop_run = loop_reg && (state_reg != IDLE);
`else
   assign loop_run = 1'b0;
`endif

   // A looping run replays stored entries in place, so it neither pops nor accepts new ones.
   assign push_ok = i_push && !o_full && !loop_run;
   assign pop     = (state_reg == WRITE) && !loop_run;

   always_comb begin
      level_next = level_reg;
      unique case ({push_ok, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      load_head  = 1'b0;
      done_next  = 1'b0;
      head_addr  = idx_reg + 1'b1;
      pos_next   = pos_reg + 1'b1;
      last_entry = ({1'b0, pos_reg} == level_reg - 1'b1);
      if (loop_run && last_entry) begin
         head_addr = rd_ptr_reg;
         pos_next  = '0;
      end
      unique case (state_reg)
         IDLE: begin
            if (i_start && level_reg != LVL_ZERO) begin
               state_next = WRITE;
               load_head  = 1'b1;
               head_addr  = rd_ptr_reg;
               pos_next   = '0;
            end
         end
         WRITE: begin
            // level_reg still counts the entry being popped this cycle
            if (i_stop) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else if (dly_reg != DLY_ZERO) begin
               state_next = WAIT;
            end else if (loop_run || level_reg > LVL_ONE) begin
               state_next = WRITE;
               load_head  = 1'b1;
            end else begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         WAIT: begin
            if (i_stop) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else if (cnt_reg == DLY_ONE) begin
               if (loop_run || level_reg != LVL_ZERO) begin
                  state_next = WRITE;
                  load_head  = 1'b1;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= {i_value, i_be, i_delay};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         idx_reg    <= '0;
         pos_reg    <= '0;
         level_reg  <= '0;
         cnt_reg    <= '0;
         dly_reg    <= '0;
         din_reg    <= '0;
         be_reg     <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         level_reg <= level_next;
         done_reg  <= done_next;
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (state_reg == WRITE)
            cnt_reg <= dly_reg;
         else if (state_reg == WAIT)
            cnt_reg <= cnt_reg - 1'b1;
         // Strobe registers are loaded on entry to WRITE so they line up with that cycle.
         if (load_head) begin
            {din_reg, be_reg, dly_reg} <= mem[head_addr];
            idx_reg <= head_addr;
            pos_reg <= pos_next;
         end else begin
            be_reg <= '0;
         end
      end
   end

   assign o_full       = (level_reg == LVL_FULL);
   assign o_level      = level_reg;
   assign o_busy       = (state_reg != IDLE);
   assign o_done       = done_reg;
   assign o_gpio_addr  = 3'b001;
   assign o_gpio_din   = din_reg;
   assign o_gpio_wr_en = be_reg;

endmodule

// File: doc/gpio_seq.md
Name: gpio_seq

Overview:
- Timed bit-bang sequencer that drives the GPIO block's register write port (i_addr / i_din / i_wr_en) without CPU involvement.
- Host pushes entries {value, byte enables, delay} into an internal buffer.
- On start, each entry becomes a one-cycle write to the GPIO data register (address 3'b001), followed by a hold of `delay` cycles.
- Sits between the CPU-side register file and the gpio instance. Its output port is muxed/arbitrated with CPU writes upstream.

Parameters:
- AW, 4: buffer address width; DEPTH = 2**AW entries.
- DLY_W, 16: width of the per-entry delay field and delay counter.

Ports:
- i_clk  in  1  clock; only clock in the block.
- i_rst  in  1  asynchronous, active-high reset.
- i_push  in  1  write one entry into the buffer.
- i_value  in  32  entry output data.
- i_be  in  4  entry byte write enables.
- i_delay  in  DLY_W  hold cycles after this entry's write.
- o_full  out  1  buffer holds DEPTH entries.
- o_level  out  AW+1  number of stored entries.
- i_start  in  1  begin sequencing (pulse).
- i_stop  in  1  abort sequencing (pulse).
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse when the sequence completes or is aborted.
- o_gpio_addr  out  3  always 3'b001 (GPIO data register).
- o_gpio_din  out  32  value of the entry being written.
- o_gpio_wr_en  out  4  byte enables; nonzero only in WRITE state.

Behaviour:
- Reset (async, i_rst=1):
  - State IDLE; pointers = 0; level = 0; delay counter = 0.
  - o_full=0, o_level=0, o_busy=0, o_done=0, o_gpio_din=0, o_gpio_wr_en=0, o_gpio_addr=3'b001.
  - Buffer RAM contents are not reset.
  - Reset mid-sequence discards all entries immediately.
- Buffer: circular, write pointer / read pointer.
  - i_push with o_full=0 stores the entry at wr_ptr and increments wr_ptr (wraps mod DEPTH).
  - i_push with o_full=1 is ignored; no state change.
  - A push and a pop in the same cycle leave the level unchanged.
  - A push is accepted while busy and may extend the running sequence.
- State machine: IDLE, WRITE, WAIT.
  - IDLE: if i_start && level!=0, go to WRITE on the next edge. i_start with level==0 is ignored (no o_done).
  - WRITE (exactly 1 cycle):
    - Drive o_gpio_din = head.value and o_gpio_wr_en = head.be.
    - Pop the head: rd_ptr+1, level-1.
    - Load counter = head.delay.
    - If head.delay!=0, go to WAIT. Otherwise go to WRITE if level after pop !=0, else go to IDLE and pulse o_done.
  - WAIT: counter decrements each cycle. When counter==1, go to WRITE if level!=0, else go to IDLE with o_done.
  - Each entry occupies 1+delay cycles. Consecutive zero-delay entries produce back-to-back write cycles.
- Latency: i_start sampled at edge N -> WRITE (strobe visible) in the cycle after edge N. o_done is asserted in the first IDLE cycle.
- i_stop:
  - In WAIT: go to IDLE on the next edge, o_done=1; remaining entries are kept.
  - In WRITE: the current write and pop complete, then go to IDLE with o_done.
  - In IDLE: ignored.
  - i_stop has priority over continuing to the next entry. Simultaneous i_start and i_stop in IDLE: start wins.
- Strobe outputs are registered from state; no combinational path from inputs to the o_gpio_* outputs.
- Be==4'b0000 entries still take their full time slot and are counted; the GPIO register is unchanged by them.

Optional Feature:
- Macro GPIO_SEQ_LOOP_EN.
- Defined:
  - Adds input port i_loop (1 bit), sampled with i_start.
  - In loop mode, WRITE does not pop; a separate index walks rd_ptr..rd_ptr+level-1.
  - After the last entry, the index wraps to rd_ptr and the sequence repeats indefinitely until i_stop.
  - i_push is ignored while a loop run is active.
  - o_done pulses only on stop.
- Undefined: no i_loop port; behaviour exactly as above.

Test Plan:
- Push {0x000000A5, be=0001, delay=3} then i_start -> one WRITE with din=0x000000A5, wr_en=0001, then 3 WAIT cycles; o_done at cycle 5 after start; o_level 1->0.
- Push 3 entries with delay=0, start -> three consecutive write cycles with values in push order; o_busy high exactly 3 cycles; o_done once.
- Push 16 entries (AW=4), a 17th push -> o_full=1, o_level=16, 17th ignored; after run, o_level=0 and all 16 values appear in order across the wraparound.
- Start, 2 entries with delay=10, i_stop in WAIT of the first -> IDLE next cycle, o_done pulse, o_level=1; second entry not written.
- Assert i_rst during WAIT -> all outputs return to reset values asynchronously; o_level=0; a subsequent i_start with empty buffer -> no activity, no o_done.
- GPIO_SEQ_LOOP_EN: 2 entries with delay=1, i_loop=1, start -> write pattern A,B,A,B... every 2 cycles; i_stop -> IDLE with o_done; o_level still 2.
